dump_sample_tx: RTL and testbench
=================================

Name: dump_sample_tx

Overview:
- Downstream of the dump state machine in the scope datapath.
- Latches the per-channel gain and offset calibration bytes returned by the EEPROM SPI reads, then fetches each raw capture sample from sample RAM on request.
- Applies offset then gain correction with saturation and hands the corrected byte to the UART transmitter.
- Its `uart_rdy` output is the ready signal the dump state machine polls.

Parameters:
- `UNITY_GAIN`, 8'h80: gain reset value; 8'h80 means ×1.0 (gain is in 1.7 fixed point).
- `CNT_W`, 16: width of the sent-byte counter.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `flop_gain` in 1: pulse; capture `spi_rx_data[7:0]` as gain.
- `flop_offset` in 1: pulse; capture `spi_rx_data[7:0]` as offset (signed).
- `spi_rx_data` in 16: SPI receive word.
- `start_resp` in 1: pulse; send sample at the current RAM address.
- `uart_rdy` out 1: high only in IDLE; ready for `start_resp`.
- `ram_re` out 1: sample RAM read enable; data is valid the next cycle.
- `ram_rdata` in 8: raw unsigned sample.
- `tx_start` out 1: one-cycle pulse to the UART TX.
- `tx_data` out 8: corrected byte; held stable from `tx_start` until `tx_done`.
- `tx_rdy` in 1: UART TX idle.
- `tx_done` in 1: pulse; byte fully shifted out.
- `sent_cnt` out `CNT_W`: bytes sent since reset.

Behaviour:
- Reset:
  - All registers load synchronously when `rst`=1.
  - State goes to IDLE; gain=`UNITY_GAIN`; offset=0; `tx_data`=0; `sent_cnt`=0.
  - `tx_start`=0, `ram_re`=0, `uart_rdy`=1 on the first cycle after reset.
  - Reset mid-transfer abandons the byte; no `tx_start` is issued afterwards.
- Calibration capture:
  - Runs independently of the state machine and in any state.
  - If `flop_gain` and `flop_offset` are both high in the same cycle, both registers load from the same `spi_rx_data[7:0]`.
  - A calibration update during a transfer affects only the computation stages it has not yet passed (gain is read in MULT, offset in ADD).
- FSM:
  - IDLE: `uart_rdy`=1. On `start_resp`, go to RDRAM. `start_resp` in any other state is ignored.
  - RDRAM: `ram_re`=1 for exactly one cycle; go to ADD.
  - ADD: s = {2'b00, ram_rdata} + sign-extended offset (10-bit signed). Saturate to an 8-bit unsigned value (s<0 → 0, s>255 → 255) and register it; go to MULT.
  - MULT: p = sat_sum × gain (16-bit unsigned). Result is 8'hFF if p[15]=1, else p[14:7] (truncation, no rounding). Register the result into `tx_data`; go to SEND.
  - SEND: hold until `tx_rdy`=1. In the cycle `tx_rdy`=1, assert `tx_start` for 1 cycle and go to WAIT.
  - WAIT: hold until `tx_done`. On `tx_done`: `sent_cnt`+1 (wraps at 2^`CNT_W`), then go to IDLE.
- Latency: `start_resp` in cycle 0 gives `ram_re` in cycle 1 and `tx_start` in cycle 4 at the earliest (if `tx_rdy` is high).
- `uart_rdy` returns high the cycle after `tx_done`.
- `tx_done` outside WAIT is ignored.
- `tx_start` is never asserted unless `tx_rdy`=1 in that same cycle.
- Throughput: one byte per `start_resp`. Nothing is queued; a second request must wait for `uart_rdy`.

Test Plan:
- Reset, no calibration loaded, `ram_rdata`=8'h5A, `start_resp`, `tx_rdy`=1 → `ram_re` at cycle 1, `tx_start` at cycle 4, `tx_data`=8'h5A; `tx_done` → `sent_cnt`=1, `uart_rdy`=1.
- `flop_offset` with 16'h00F6 (−10), `flop_gain` with 16'h00C0 (×1.5), sample 8'h40 → (64−10)×192>>7 = 81, so `tx_data`=8'h51.
- Saturation:
  - sample 8'h03, offset −10 → `tx_data`=8'h00.
  - sample 8'hFA, offset +20 → sum 255; with gain 8'hFF, p=0xFE01, p[15]=1 → `tx_data`=8'hFF.
- `tx_rdy`=0 for 5 cycles in SEND → no `tx_start`; `tx_data` held; `tx_start` on the first cycle `tx_rdy`=1. Extra `start_resp` pulses during WAIT are ignored, and `sent_cnt` increments only once.
- `rst` asserted in the WAIT state → next cycle IDLE, gain=8'h80, offset=0, `sent_cnt`=0; a later `tx_done` does not increment `sent_cnt`.
- Drive 256 back-to-back requests with `CNT_W`=8 → `sent_cnt` wraps to 0; `flop_gain` and `flop_offset` asserted together with 16'h0010 → gain=offset=8'h10.

Source files
------------

// File: rtl/dump_sample_tx.sv
// Sample dump transmitter: fetches a raw capture sample, applies offset then
// gain calibration with saturation, and hands the corrected byte to the UART.
module dump_sample_tx #(
    parameter logic [7:0]  UNITY_GAIN = 8'h80,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flop_gain,
    input  logic             flop_offset,
    input  logic [15:0]      spi_rx_data,
    input  logic             start_resp,
    output logic             uart_rdy,
    output logic             ram_re,
    input  logic [7:0]       ram_rdata,
    output logic             tx_start,
    output logic [7:0]       tx_data,
    input  logic             tx_rdy,
    input  logic             tx_done,
    output logic [CNT_W-1:0] sent_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RDRAM,
        S_ADD,
        S_MULT,
        S_SEND,
        S_WAIT
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [7:0]  gain;
    logic [7:0]  offset;
    logic [7:0]  sat_sum;
    logic [9:0]  sum_ext;
    logic [7:0]  sum_sat_c;
    logic [15:0] prod;
    logic [7:0]  mult_res_c;
    logic        unused_bits;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start_resp) state_nxt = S_RDRAM;
            S_RDRAM: state_nxt = S_ADD;
            S_ADD:   state_nxt = S_MULT;
            S_MULT:  state_nxt = S_SEND;
            S_SEND:  if (tx_rdy) state_nxt = S_WAIT;
            S_WAIT:  if (tx_done) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs decoded from state; tx_start is gated by tx_rdy in the same cycle
    always_comb begin
        uart_rdy = 1'b0;
        ram_re   = 1'b0;
        tx_start = 1'b0;
        case (state)
            S_IDLE:  uart_rdy = 1'b1;
            S_RDRAM: ram_re   = 1'b1;
            S_SEND:  tx_start = tx_rdy;
            default: ;
        endcase
    end

    // Offset add in 10-bit signed, clamped to the unsigned byte range
    always_comb begin
        sum_ext = {2'b00, ram_rdata} + {{2{offset[7]}}, offset};
        if (sum_ext[9]) begin
            sum_sat_c = 8'h00;
        end else if (sum_ext[8]) begin
            sum_sat_c = 8'hFF;
        end else begin
            sum_sat_c = sum_ext[7:0];
        end
    end

    // Gain is 1.7 fixed point: drop 7 fraction bits, clamp on integer overflow
    always_comb begin
        prod       = 16'(sat_sum) * 16'(gain);
        mult_res_c = prod[15] ? 8'hFF : prod[14:7];
    end

    assign unused_bits = ^{spi_rx_data[15:8], prod[6:0]};

    // Calibration capture runs in every state
    always_ff @(posedge clk) begin
        if (rst) begin
            gain   <= UNITY_GAIN;
            offset <= 8'h00;
        end else begin
            if (flop_gain) gain <= spi_rx_data[7:0];
            if (flop_offset) offset <= spi_rx_data[7:0];
        end
    end

    // Datapath stages and sent-byte counter
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_sum  <= 8'h00;
            tx_data  <= 8'h00;
            sent_cnt <= '0;
        end else begin
            if (state == S_ADD) sat_sum <= sum_sat_c;
            if (state == S_MULT) tx_data <= mult_res_c;
            if (state == S_WAIT && tx_done) sent_cnt <= sent_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_dump_sample_tx.sv
// Directed bench for dump_sample_tx: vector table of calibrated transfers plus
// hand sequences for reset mid-transfer, joint calibration load and counter wrap.
module tb_dump_sample_tx;

    localparam int unsigned CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             flop_gain;
    logic             flop_offset;
    logic [15:0]      spi_rx_data;
    logic             start_resp;
    logic             uart_rdy;
    logic             ram_re;
    logic [7:0]       ram_rdata;
    logic             tx_start;
    logic [7:0]       tx_data;
    logic             tx_rdy;
    logic             tx_done;
    logic [CNT_W-1:0] sent_cnt;

    logic [7:0]       cur_sample;
    logic [CNT_W-1:0] exp_cnt;
    int               total = 0;
    int               bad   = 0;

    typedef struct {
        bit         ld_gain;
        logic [7:0] gain_w;
        bit         ld_off;
        logic [7:0] off_w;
        logic [7:0] sample;
        logic [7:0] exp;
        int         stall;
        bit         extra;
    } vec_t;

    vec_t vecs[8];

    dump_sample_tx #(.UNITY_GAIN(8'h80), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .flop_gain   (flop_gain),
        .flop_offset (flop_offset),
        .spi_rx_data (spi_rx_data),
        .start_resp  (start_resp),
        .uart_rdy    (uart_rdy),
        .ram_re      (ram_re),
        .ram_rdata   (ram_rdata),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_rdy      (tx_rdy),
        .tx_done     (tx_done),
        .sent_cnt    (sent_cnt)
    );

    always #5 clk = ~clk;

    // Sample RAM model: one-cycle read latency, junk when not read
    always @(posedge clk) begin
        ram_rdata <= ram_re ? cur_sample : 8'hEE;
    end

    always @(negedge clk) begin
        if (tx_start === 1'b1 && tx_rdy !== 1'b1) begin
            bad++;
            $display("FAIL tx_start_gate: tx_start=1 while tx_rdy=%b", tx_rdy);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic load_cal(input logic [15:0] w, input bit g, input bit o);
        spi_rx_data = w;
        flop_gain   = g;
        flop_offset = o;
        @(posedge clk); #1;
        flop_gain   = 1'b0;
        flop_offset = 1'b0;
    endtask

    // One full request: starts #1 after a posedge with the DUT idle
    task automatic run_txn(input string name, input logic [7:0] sample, input logic [7:0] exp,
                           input int stall, input bit extra);
        chk({name, "/uart_rdy_pre"}, 32'(uart_rdy), 32'd1);
        cur_sample = sample;
        tx_rdy     = 1'b0;
        start_resp = 1'b1;
        @(posedge clk); #1;
        start_resp = 1'b0;
        chk({name, "/ram_re_c1"}, 32'(ram_re), 32'd1);
        chk({name, "/uart_rdy_busy"}, 32'(uart_rdy), 32'd0);
        for (int c = 2; c <= 4 + stall; c++) begin
            @(posedge clk); #1;
            tx_rdy = (c == 4 + stall);
            #1;
            chk($sformatf("%s/tx_start_c%0d", name, c), 32'(tx_start), 32'(c == 4 + stall));
            if (c >= 4) chk($sformatf("%s/tx_data_c%0d", name, c), 32'(tx_data), 32'(exp));
        end
        @(posedge clk); #1;
        tx_rdy = 1'b0;
        #1;
        chk({name, "/tx_start_wait"}, 32'(tx_start), 32'd0);
        if (extra) begin
            for (int k = 0; k < 2; k++) begin
                start_resp = 1'b1;
                @(posedge clk); #1;
                start_resp = 1'b0;
                chk({name, "/ram_re_ignored"}, 32'(ram_re), 32'd0);
                chk({name, "/uart_rdy_wait"}, 32'(uart_rdy), 32'd0);
            end
        end
        tx_done = 1'b1;
        @(posedge clk); #1;
        tx_done = 1'b0;
        exp_cnt = exp_cnt + CNT_W'(1);
        chk({name, "/sent_cnt"}, 32'(sent_cnt), 32'(exp_cnt));
        chk({name, "/uart_rdy_post"}, 32'(uart_rdy), 32'd1);
        chk({name, "/tx_data_held"}, 32'(tx_data), 32'(exp));
    endtask

    initial begin
        //            ld_g  gain   ld_o  off    sample exp    stall extra
        vecs[0] = '{1'b0, 8'h00, 1'b0, 8'h00, 8'h5A, 8'h5A, 0, 1'b0};
        vecs[1] = '{1'b1, 8'hC0, 1'b1, 8'hF6, 8'h40, 8'h51, 0, 1'b0};
        vecs[2] = '{1'b0, 8'h00, 1'b0, 8'h00, 8'h03, 8'h00, 0, 1'b0};
        vecs[3] = '{1'b1, 8'hFF, 1'b1, 8'h14, 8'hFA, 8'hFF, 0, 1'b0};
        vecs[4] = '{1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 8'h27, 5, 1'b1};
        vecs[5] = '{1'b1, 8'h80, 1'b1, 8'h80, 8'hFF, 8'h7F, 0, 1'b0};
        vecs[6] = '{1'b1, 8'h40, 1'b1, 8'h7F, 8'h10, 8'h47, 0, 1'b0};
        vecs[7] = '{1'b1, 8'h00, 1'b0, 8'h00, 8'h80, 8'h00, 0, 1'b0};

        rst         = 1'b1;
        flop_gain   = 1'b0;
        flop_offset = 1'b0;
        spi_rx_data = 16'h0000;
        start_resp  = 1'b0;
        tx_rdy      = 1'b0;
        tx_done     = 1'b0;
        cur_sample  = 8'h00;
        exp_cnt     = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("reset/uart_rdy", 32'(uart_rdy), 32'd1);
        chk("reset/ram_re", 32'(ram_re), 32'd0);
        chk("reset/tx_start", 32'(tx_start), 32'd0);
        chk("reset/tx_data", 32'(tx_data), 32'd0);
        chk("reset/sent_cnt", 32'(sent_cnt), 32'd0);

        // tx_done while idle must not count
        tx_done = 1'b1;
        @(posedge clk); #1;
        tx_done = 1'b0;
        chk("idle_done/sent_cnt", 32'(sent_cnt), 32'd0);

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].ld_gain) load_cal({8'h00, vecs[i].gain_w}, 1'b1, 1'b0);
            if (vecs[i].ld_off) load_cal({8'h00, vecs[i].off_w}, 1'b0, 1'b1);
            run_txn($sformatf("vec%0d", i), vecs[i].sample, vecs[i].exp,
                    vecs[i].stall, vecs[i].extra);
        end

        // Joint gain/offset load from the low byte only
        load_cal(16'hAB10, 1'b1, 1'b1);
        run_txn("joint_cal", 8'h70, 8'h10, 0, 1'b0);

        // Reset while waiting for tx_done
        cur_sample = 8'h33;
        tx_rdy     = 1'b1;
        start_resp = 1'b1;
        @(posedge clk); #1;
        start_resp = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wait/tx_start", 32'(tx_start), 32'd1);
        @(posedge clk); #1;
        tx_rdy = 1'b0;
        chk("rst_wait/in_wait", 32'(uart_rdy), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_cnt = '0;
        chk("rst_wait/uart_rdy", 32'(uart_rdy), 32'd1);
        chk("rst_wait/sent_cnt", 32'(sent_cnt), 32'd0);
        chk("rst_wait/tx_data", 32'(tx_data), 32'd0);
        tx_done = 1'b1;
        @(posedge clk); #1;
        tx_done = 1'b0;
        chk("rst_wait/late_done", 32'(sent_cnt), 32'd0);
        chk("rst_wait/no_start", 32'(tx_start), 32'd0);

        // 256 requests at unity gain / zero offset; counter wraps to zero
        for (int n = 0; n < 256; n++) begin
            run_txn($sformatf("wrap%0d", n), 8'(n), 8'(n), 0, 1'b0);
        end
        chk("wrap/sent_cnt_zero", 32'(sent_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
